// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared tile-map and collision definitions for the character scanners
// Tile codes returned by the tile-map ROM, playfield geometry and the
// collision_state bit layout shared with the motion stage.
package game_pkg;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_SOLID = 2'd1;
    localparam logic [1:0] TILE_FIRE  = 2'd2;
    localparam logic [1:0] TILE_WATER = 2'd3;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int MAP_COLS   = 40;
    localparam int TILE_SHIFT = 4;

    // Bit positions inside collision_state. These equal the probe side
    // index k[2:1], so the scanner can use the side index directly.
    localparam int COL_UP    = 0;
    localparam int COL_DOWN  = 1;
    localparam int COL_RIGHT = 2;
    localparam int COL_LEFT  = 3;

endpackage

// File: rtl/tile_probe_addr.sv
// rtl/tile_probe_addr.sv - combinational probe point to tile-ROM address mapper
// Ports:
//   x, y  : character top-left corner in pixels
//   k     : probe index 0..7 (k[2:1] = side up/down/right/left, k[0] = second corner)
//   addr  : tile ROM address row*40 + col, 0 when the probe is off-screen
//   oob   : probe point lies outside the playfield
module tile_probe_addr
    import game_pkg::*;
#(
    parameter int CHAR_W     = 16,
    parameter int CHAR_H     = 16,
    parameter int SCR_W      = SCREEN_W,
    parameter int SCR_H      = SCREEN_H,
    parameter int T_SHIFT    = TILE_SHIFT
) (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [2:0]  k,
    output logic [10:0] addr,
    output logic        oob
);

    logic [10:0] xe;
    logic [10:0] ye;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] col;
    logic [10:0] row;
    logic        side_oob;

    assign xe = {1'b0, x};
    assign ye = {2'b00, y};

    always_comb begin
        px       = xe;
        py       = ye;
        side_oob = 1'b0;
        case (k[2:1])
            2'd0: begin
                px       = k[0] ? xe + 11'(CHAR_W - 1) : xe;
                py       = ye - 11'd1;
                side_oob = (y == 9'd0);
            end
            2'd1: begin
                px = k[0] ? xe + 11'(CHAR_W - 1) : xe;
                py = ye + 11'(CHAR_H);
            end
            2'd2: begin
                px = xe + 11'(CHAR_W);
                py = k[0] ? ye + 11'(CHAR_H - 1) : ye;
            end
            default: begin
                px       = xe - 11'd1;
                py       = k[0] ? ye + 11'(CHAR_H - 1) : ye;
                side_oob = (x == 10'd0);
            end
        endcase

        oob = side_oob || (px >= 11'(SCR_W)) || (py >= 11'(SCR_H));
        col = px >> T_SHIFT;
        row = py >> T_SHIFT;
        // row*40 as two shifts; only the 40-column map is supported.
        addr = oob ? 11'd0 : (row << 5) + (row << 3) + col;
    end

endmodule

// File: rtl/collision_scan_blue.sv
// rtl/collision_scan_blue.sv - per-frame tile-map collision scanner for the blue character
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : frame-tick pulse requesting a scan (ignored while busy)
//   cur_x, cur_y     : character top-left corner in pixels
//   rom_addr         : tile ROM address for the probe issued this cycle
//   rom_data         : tile code, valid one cycle after rom_addr
//   collision_state  : {left, right, down, up} blocked flags
//   hazard           : fire tile directly below the character
//   busy             : scan in progress
//   done             : one-cycle pulse in the cycle the new results appear
module collision_scan_blue
    import game_pkg::*;
#(
    parameter int CHAR_W = 16,
    parameter int CHAR_H = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  cur_x,
    input  logic [8:0]  cur_y,
    output logic [10:0] rom_addr,
    input  logic [1:0]  rom_data,
    output logic [3:0]  collision_state,
    output logic        hazard,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_q;
    logic [2:0]  k_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;

    // One-cycle delayed copy of the issued probe, aligned with rom_data.
    logic        pvalid_q;
    logic [1:0]  pside_q;
    logic        poob_q;

    logic [3:0]  shadow_q;
    logic [3:0]  shadow_d;
    logic        haz_sh_q;
    logic        haz_sh_d;
    logic [3:0]  collision_q;
    logic        hazard_q;

    logic [10:0] probe_addr;
    logic        probe_oob;
    logic        blocked;
    logic        fire;

    tile_probe_addr #(
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H)
    ) u_probe (
        .x    (x_q),
        .y    (y_q),
        .k    (k_q),
        .addr (probe_addr),
        .oob  (probe_oob)
    );

    assign rom_addr = (state_q == ST_ISSUE) ? probe_addr : 11'd0;

    always_comb begin
        // Off-screen probes read address 0; their data is overridden to SOLID.
        blocked  = pvalid_q && (poob_q || (rom_data == TILE_SOLID));
        fire     = pvalid_q && !poob_q && (rom_data == TILE_FIRE) && (pside_q == 2'(COL_DOWN));
        shadow_d = shadow_q;
        if (blocked) begin
            shadow_d[pside_q] = 1'b1;
        end
        haz_sh_d = haz_sh_q || fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            pvalid_q    <= 1'b0;
            pside_q     <= 2'd0;
            poob_q      <= 1'b0;
            shadow_q    <= 4'd0;
            haz_sh_q    <= 1'b0;
            collision_q <= 4'b0010;
            hazard_q    <= 1'b0;
        end else begin
            pvalid_q <= (state_q == ST_ISSUE);
            pside_q  <= k_q[2:1];
            poob_q   <= probe_oob;
            shadow_q <= shadow_d;
            haz_sh_q <= haz_sh_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q      <= cur_x;
                        y_q      <= cur_y;
                        k_q      <= 3'd0;
                        shadow_q <= 4'd0;
                        haz_sh_q <= 1'b0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last probe's data is on rom_data now; publish the full scan.
                    collision_q <= shadow_d;
                    hazard_q    <= haz_sh_d;
                    state_q     <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign collision_state = collision_q;
    assign hazard          = hazard_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_collision_scan_blue.sv
// tb/tb_collision_scan_blue.sv - directed-vector bench for collision_scan_blue
module tb_collision_scan_blue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  cur_x;
    logic [8:0]  cur_y;
    logic [10:0] rom_addr;
    logic [1:0]  rom_data;
    logic [3:0]  collision_state;
    logic        hazard;
    logic        busy;
    logic        done;

    logic [1:0]  map_q [0:1199];

    int vectors    = 0;
    int miscompares = 0;

    int done_cnt, done_at1, done_at2, busy_miss, busy11;
    int a_k0, a_k6, a_k7;
    int busy_rst, cs_rst;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data <= (rom_addr < 11'd1200) ? map_q[rom_addr] : 2'd0;
    end

    collision_scan_blue dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cur_x           (cur_x),
        .cur_y           (cur_y),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .collision_state (collision_state),
        .hazard          (hazard),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_map(input int floor_row);
        for (int i = 0; i < 1200; i++) begin
            map_q[i] = (i >= floor_row * 40) ? 2'd1 : 2'd0;
        end
    endtask

    // Start pulse in cycle 0; extra start pulses in cycles p1/p2 and a reset
    // pulse in cycle rc (0 = none). Cycle n is sampled at its falling edge.
    task automatic scan(input int x, input int y, input int p1, input int p2, input int rc);
        @(negedge clk);
        cur_x = 10'(x);
        cur_y = 9'(y);
        start = 1'b1;
        done_cnt = 0; done_at1 = 0; done_at2 = 0; busy_miss = 0; busy11 = -1;
        a_k0 = -1; a_k6 = -1; a_k7 = -1; busy_rst = -1; cs_rst = -1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_at1 = n;
                else if (done_cnt == 2) done_at2 = n;
            end
            if (n <= 10 && !busy) busy_miss++;
            if (n == 11) busy11 = int'(busy);
            if (n == 1) a_k0 = int'(rom_addr);
            if (n == 7) a_k6 = int'(rom_addr);
            if (n == 8) a_k7 = int'(rom_addr);
            if (rc != 0 && n == rc + 1) begin
                busy_rst = int'(busy);
                cs_rst   = int'(collision_state);
            end
            start = (n == p1) || (n == p2);
            rst   = (rc != 0) && (n == rc);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cur_x = 10'd0; cur_y = 9'd0;
        fill_map(30);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cs", int'(collision_state), 2);
        check("reset_hazard", int'(hazard), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_addr", int'(rom_addr), 0);

        // Flat floor at rows 15+.
        fill_map(15);
        scan(100, 224, 0, 0, 0);
        check("floor_latency", done_at1, 10);
        check("floor_done_cnt", done_cnt, 1);
        check("floor_busy", busy_miss, 0);
        check("floor_busy_after", busy11, 0);
        check("floor_cs", int'(collision_state), 2);
        check("floor_hazard", int'(hazard), 0);

        // Left screen edge, empty map.
        fill_map(30);
        scan(0, 100, 0, 0, 0);
        check("left_cs", int'(collision_state), 8);
        check("left_addr_k0", a_k0, 240);
        check("left_addr_k6", a_k6, 0);
        check("left_addr_k7", a_k7, 0);

        // Top-right corner: up and right off-screen.
        scan(624, 0, 0, 0, 0);
        check("topright_cs", int'(collision_state), 5);

        // Bottom edge: down probes below the playfield.
        scan(300, 464, 0, 0, 0);
        check("bottom_cs", int'(collision_state), 2);

        // Wall tile (8,6).
        fill_map(30);
        map_q[248] = 2'd1;
        scan(112, 96, 0, 0, 0);
        check("wall_cs", int'(collision_state), 4);
        check("wall_hazard", int'(hazard), 0);

        // Fire pit at tile (6,15), then water.
        fill_map(30);
        map_q[606] = 2'd2;
        scan(96, 224, 0, 0, 0);
        check("fire_hazard", int'(hazard), 1);
        check("fire_cs", int'(collision_state), 0);
        map_q[606] = 2'd3;
        scan(96, 224, 0, 0, 0);
        check("water_hazard", int'(hazard), 0);
        check("water_cs", int'(collision_state), 0);

        // Busy restart: start at T+4 ignored, start at T+11 accepted.
        fill_map(30);
        map_q[248] = 2'd1;
        scan(112, 96, 4, 11, 0);
        check("restart_cnt", done_cnt, 2);
        check("restart_first", done_at1, 10);
        check("restart_second", done_at2, 21);
        check("restart_cs", int'(collision_state), 4);

        // Start during the DONE cycle is ignored.
        scan(112, 96, 10, 0, 0);
        check("donecycle_cnt", done_cnt, 1);

        // Reset mid-scan in cycle T+5.
        scan(0, 100, 0, 0, 5);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_busy", busy_rst, 0);
        check("rst_cs", cs_rst, 2);
        scan(112, 96, 0, 0, 0);
        check("post_rst_latency", done_at1, 10);
        check("post_rst_cs", int'(collision_state), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collision_scan_blue.md
Name: collision_scan_blue

Overview:
- Upstream neighbour of the blue-character motion stage.
- Once per frame tick, probes the tile-map ROM around the character's bounding box and produces the 4-bit collision_state consumed by the motion stage.
- Also flags a fire hazard under the character's feet.
- Fixed-latency sequential scanner: 8 probes pipelined through a 1-cycle synchronous ROM.

Parameters:
- CHAR_W, 16, character width in pixels (1..32).
- CHAR_H, 16, character height in pixels (1..32).
- TILE_SHIFT, 4, log2 of tile size in pixels (16x16 tiles).
- MAP_COLS, 40, tiles per row.
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame-tick pulse requesting a scan
- cur_x  in  10  character left edge, pixels
- cur_y  in  9  character top edge, pixels
- rom_addr  out  11  tile ROM address = row*MAP_COLS + col
- rom_data  in  2  tile code returned by ROM one cycle after rom_addr
- collision_state  out  4  [0]=up, [1]=down, [2]=right, [3]=left blocked
- hazard  out  1  fire tile directly below the character
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when collision_state/hazard update

Behaviour:
- Reset values:
  - collision_state=4'b0010 (grounded, so nothing falls before the first scan); hazard=0; busy=0; done=0; rom_addr=0.
  - FSM returns to IDLE. Reset mid-scan aborts the scan; no done is produced.
- FSM states and transitions:
  - IDLE: on start, latch cur_x/cur_y → ISSUE.
  - ISSUE: 8 cycles, probe index k=0..7 → DRAIN.
  - DRAIN: 1 cycle → DONE.
  - DONE: 1 cycle → IDLE.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Latency: start sampled at cycle T; probes issued T+1..T+8; ROM data returns T+2..T+9; registered outputs and the done pulse appear at T+10. Latency is exactly 10 cycles regardless of probe outcome.
- busy is high from T+1 through T+10 inclusive.
- Probe points (x, y = latched values):
  - k0/k1 up: (x, y-1), (x+CHAR_W-1, y-1)
  - k2/k3 down: (x, y+CHAR_H), (x+CHAR_W-1, y+CHAR_H)
  - k4/k5 right: (x+CHAR_W, y), (x+CHAR_W, y+CHAR_H-1)
  - k6/k7 left: (x-1, y), (x-1, y+CHAR_H-1)
- Arithmetic and width rules:
  - Compute probe coordinates 11 bits wide to avoid wrap.
  - Out of bounds: x=0 for left probes, y=0 for up probes, px>=SCREEN_W, py>=SCREEN_H.
  - Out-of-bounds probes still consume their slot, drive rom_addr=0, and their result is forced SOLID. Screen edges therefore act as walls and floor.
  - col = px>>TILE_SHIFT; row = py>>TILE_SHIFT; addr = row*40 + col, implemented as (row<<5)+(row<<3)+col.
- Tile codes: EMPTY=0, SOLID=1, FIRE=2, WATER=3.
  - A probe is blocked iff its code is SOLID.
  - A side's bit = OR of its two probes.
- hazard = either down probe returns FIRE. WATER is safe for blue.
- Results accumulate in a shadow register. collision_state and hazard update only at DONE, so the motion stage never sees a partial scan.
- Between scans, outputs hold their last values.

Decomposition:
- Shared package game_pkg:
  - tile code localparams (TILE_EMPTY/SOLID/FIRE/WATER)
  - SCREEN_W/H, MAP_COLS, TILE_SHIFT
  - collision bit indices (COL_UP=0, COL_DOWN=1, COL_RIGHT=2, COL_LEFT=3); the motion stage uses the same indices.
- One natural sub-module: tile_probe_addr. It is combinational: (x, y, k) → rom_addr and oob flag. It is reusable by the red character's scanner.
- The ROM is external.

Test Plan:
- Flat floor: rows ≥15 SOLID, rest EMPTY; start with cur_x=100, cur_y=224 → done at T+10, collision_state=4'b0010, hazard=0, busy high T+1..T+10.
- Left screen edge: cur_x=0, cur_y=100, all-EMPTY map → collision_state[3]=1, other bits 0. rom_addr=0 during slots k6/k7.
- Wall to the right: SOLID tile at col 8, row 6; cur_x=112, cur_y=96 → probe (128,96) hits tile (8,6); collision_state=4'b0100.
- Fire pit: tile (6,15) FIRE, rest EMPTY; cur_x=96, cur_y=224 → hazard=1, collision_state[1]=0. Changing that tile to WATER → hazard=0.
- Busy/restart: start pulses at T and T+4 → exactly one done at T+10; a new start at T+11 is accepted and gives done at T+21.
- Reset mid-scan: rst at T+5 → no done pulse, collision_state=4'b0010, busy=0 next cycle; a subsequent start completes normally.
